// File: rtl/multi_edge_detector.sv
// multi_edge_detector: per-channel synchronise, debounce and rising/falling edge tick generation
module multi_edge_detector #(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4,
  parameter int CNT_W       = $clog2(DEBOUNCE + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CHANNELS-1:0]     lvl,
  input  logic [2*CHANNELS-1:0]   mode,
  output logic [CHANNELS-1:0]     lvl_db,
  output logic [CHANNELS-1:0]     tck,
  output logic                    any_tck
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);
  logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q, sync_d;
  logic [CHANNELS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [CHANNELS-1:0] lvl_db_q, lvl_db_d, tck_q, tck_d, s, acc;
  logic any_tck_q, any_tck_d;
  assign s = sync_q[SYNC_STAGES-1];
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], lvl};
    acc = '0;
    cnt_d = '0;
    lvl_db_d = lvl_db_q;
    tck_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      acc[i] = (s[i] != lvl_db_q[i]) && (cnt_q[i] == CNT_MAX);
      cnt_d[i] = (s[i] == lvl_db_q[i] || acc[i]) ? '0 : cnt_q[i] + 1'b1;
      lvl_db_d[i] = acc[i] ? s[i] : lvl_db_q[i];
      tck_d[i] = acc[i] && (s[i] ? mode[2*i] : mode[2*i+1]);
    end
    any_tck_d = |tck_d;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      cnt_q <= '0;
      lvl_db_q <= '0;
      tck_q <= '0;
      any_tck_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q <= cnt_d;
      lvl_db_q <= lvl_db_d;
      tck_q <= tck_d;
      any_tck_q <= any_tck_d;
    end
  end
  assign lvl_db = lvl_db_q;
  assign tck = tck_q;
  assign any_tck = any_tck_q;
endmodule
